title_text_renderer: RTL
========================

# title_text_renderer

Scanline renderer for the "PACMAN" title banner. During horizontal blanking it fetches one 24-bit row per character from the big-font glyph ROM for the upcoming scanline. During active video it shifts those rows out as a 1-bit `text_on` pixel mask, which the colour mapper combines with the maze and sprite layers.

## Interface
Parameters:
- `TEXT_X`, 240: first pixel column of the banner.
- `TEXT_Y`, 100: first scanline of the banner.
- `NUM_CHARS`, 6: characters in the string.
- `GLYPH_W`, 24: pixels per glyph row, which is also the ROM data width.
- `GLYPH_H`, 36: glyph rows rendered, counted from glyph row 0.
- `GLYPH_STRIDE`, 64: ROM words per glyph.

Ports (one clock; reset is asynchronous and active-low):
- `Clk`  in  1: pixel clock. One `DrawX` step per cycle.
- `Reset_n`  in  1: asynchronous active-low reset.
- `line_start`  in  1: one-cycle pulse at the start of hblank for line L.
- `next_line`  in  10: L+1, sampled on `line_start`.
- `DrawX`  in  10: current pixel column.
- `DrawY`  in  10: current scanline.
- `rom_addr`  out  9: glyph ROM address, driven from a register.
- `rom_data`  in  24: ROM row for `rom_addr`, valid the cycle after the address is driven.
- `text_on`  out  1: banner pixel, registered.
- `busy`  out  1: row fetch in progress.

## Operation
- String: glyph codes P=0, A=1, C=2, M=3, A=1, N=4. The ROM address for character k is `code[k]*GLYPH_STRIDE + grow`.
- Band: `next_line` is in the text band when `TEXT_Y <= next_line < TEXT_Y + GLYPH_H`. Glyph row `grow = next_line - TEXT_Y`.
- FSM states: IDLE, FETCH, LAST, DONE.
  - IDLE, `line_start` with `next_line` in band: go to FETCH, k=0, `busy`=1.
  - IDLE, `line_start` with `next_line` out of band: clear the row buffer to zero and stay in IDLE.
  - FETCH: drive the address for k. From the second FETCH cycle on, capture `rom_data` into `buf[k-1]`. Increment k. When k = NUM_CHARS-1 has been issued, go to LAST.
  - LAST: capture `buf[NUM_CHARS-1]`, go to DONE.
  - DONE: one cycle. Set `row_valid`, drop `busy`, go to IDLE.
- A `line_start` arriving in any non-IDLE state aborts the current fetch, clears `row_valid` and restarts at k=0 with the new `next_line`.
- Display path:
  - When `DrawX == TEXT_X`, load `char_idx`=0, `col`=0.
  - Each following cycle, `col` increments. At `col == GLYPH_W-1` it wraps to 0 and `char_idx` increments.
  - The span ends after `char_idx == NUM_CHARS-1` wraps.
  - `text_on` = `row_valid` & in-span & `buf[char_idx][GLYPH_W-1-col]`. Bit 23 is the leftmost pixel.
  - `DrawY` is used only to gate `row_valid`: the buffered row applies only when `DrawY` equals the captured `next_line`.
- Arithmetic:
  - `grow` is computed at 10 bits, then truncated to 6.
  - `rom_addr` is a 9-bit sum with no overflow: the maximum is 4*64+63 = 319.

## Timing
- Reset values: `rom_addr`=0, `text_on`=0, `busy`=0, FSM in IDLE, `row_valid`=0, buffer all zero, counters zero.
- Fetch latency is NUM_CHARS+2 cycles from `line_start` to `row_valid`, which is 8 for the defaults. This fits well inside hblank, which is at least 160 cycles.
- `text_on` lags `DrawX`/`DrawY` by exactly one cycle.
- The first banner pixel appears the cycle after `DrawX == TEXT_X`.
- `line_start` in the same cycle as DONE: the restart wins and `row_valid` stays 0.
- Reset asserted mid-fetch: everything returns to the reset values immediately. The next `line_start` after release starts a fresh fetch.

## Configuration
- `TITLE_DOUBLE_EN` defined: vertical 2x scaling.
  - Band height becomes 2*GLYPH_H.
  - `grow = (next_line - TEXT_Y) >> 1`.
  - Horizontal behaviour is unchanged.
- `TITLE_DOUBLE_EN` undefined: band height GLYPH_H, `grow = next_line - TEXT_Y`.

## Structure
- Package `title_pkg` holds:
  - the glyph code enum (G_P, G_A, G_C, G_M, G_N);
  - `GLYPH_STRIDE`, `GLYPH_W`, `GLYPH_H`;
  - the `TITLE_STR` constant array of codes;
  - the FSM state typedef.
- One sub-module, `title_row_fetch`, contains the FSM, address generation and row buffer. The top level holds the display counters and the `text_on` register.

## Test plan
- Reset: hold `Reset_n`=0 with toggling inputs, then release. Required: `text_on`=0, `busy`=0, `rom_addr`=0.
- Fetch order: `line_start` with `next_line`=106. Required: `rom_addr` sequence 6, 70, 134, 198, 70, 262 on consecutive cycles, `busy` high for 7 cycles, `row_valid` 8 cycles after `line_start`.
- Pixels on row 106 (P row = 111111111111111111000000):
  - `DrawX`=240 gives `text_on`=1 one cycle later.
  - `DrawX`=257 gives 1.
  - `DrawX`=258 gives 0.
  - `DrawX`=239 gives 0.
  - `DrawX`=384 (span end) gives 0.
- Out of band: `line_start` with `next_line`=99, then 136. Required: no ROM fetch and `text_on`=0 across the entire line.
- Abort: a second `line_start` (`next_line`=110) three cycles into the fetch for 106. Required: addresses restart at 10, 74, ... and the displayed row is glyph row 10.
- With `TITLE_DOUBLE_EN`: `next_line`=113 fetches grow 6 (addresses 6, 70, ...), and `next_line`=171 is still in band (grow 35).

Source files
------------

// File: rtl/title_pkg.sv
// Shared definitions for the PACMAN title banner renderer: glyph codes,
// font geometry, the banner string and the row-fetch FSM state type.
// The optional TITLE_DOUBLE_EN macro (vertical 2x scaling) is consumed by
// title_row_fetch.
package title_pkg;

    localparam int NUM_CHARS    = 6;
    localparam int GLYPH_W      = 24;
    localparam int GLYPH_H      = 36;
    localparam int GLYPH_STRIDE = 64;

    // Glyph index in the big-font ROM (GLYPH_STRIDE words per glyph)
    typedef enum logic [2:0] {
        G_P = 3'd0,
        G_A = 3'd1,
        G_C = 3'd2,
        G_M = 3'd3,
        G_N = 3'd4
    } glyph_code_e;

    // Banner text, leftmost character first
    localparam glyph_code_e TITLE_STR [NUM_CHARS] = '{G_P, G_A, G_C, G_M, G_A, G_N};

    // Row-fetch sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LAST  = 2'd2,
        S_DONE  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/title_row_fetch.sv
// Row fetch for the title banner: during hblank, reads one ROM row per
// character for the upcoming scanline into a row buffer.
// Macro TITLE_DOUBLE_EN: band is 2*GLYPH_H lines tall and each glyph row is
// shown on two consecutive scanlines. Undefined: band is GLYPH_H lines.
// Handshake: a one-cycle i_line_start pulse starts (or restarts) a fetch;
// o_row_valid rises NUM_CHARS+2 cycles later and is only asserted while
// i_draw_y equals the line that was fetched.
module title_row_fetch
    import title_pkg::*;
#(
    parameter int TEXT_Y       = 100,
    parameter int NUM_CHARS    = 6,
    parameter int GLYPH_W      = 24,
    parameter int GLYPH_H      = 36,
    parameter int GLYPH_STRIDE = 64
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_line_start,
    input  logic [9:0]                        i_next_line,
    input  logic [9:0]                        i_draw_y,
    input  logic [GLYPH_W-1:0]                i_rom_data,
    output logic [8:0]                        o_rom_addr,
    output logic [NUM_CHARS-1:0][GLYPH_W-1:0] o_row,
    output logic                              o_row_valid,
    output fetch_state_e                      o_state
);

    localparam int K_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam logic [K_W-1:0] LAST_K = K_W'(NUM_CHARS - 1);
`ifdef TITLE_DOUBLE_EN
    localparam int BAND_H = 2 * GLYPH_H;
`else
    localparam int BAND_H = GLYPH_H;
`endif

    fetch_state_e                      r_state;
    fetch_state_e                      w_next_state;
    logic [K_W-1:0]                    r_k;
    logic [5:0]                        r_grow;
    logic [9:0]                        r_line;
    logic                              r_row_valid;
    logic [8:0]                        r_rom_addr;
    logic [NUM_CHARS-1:0][GLYPH_W-1:0] r_buf;
    logic [9:0]                        w_diff;
    logic                              w_in_band;
    logic [5:0]                        w_grow;

    // ROM word for character k at glyph row g; max 4*64+63 fits in 9 bits
    function automatic logic [8:0] f_addr(input logic [K_W-1:0] k, input logic [5:0] g);
        return 9'(TITLE_STR[k]) * 9'(GLYPH_STRIDE) + {3'b000, g};
    endfunction

    // Band test and glyph row for the line being announced
    always_comb begin
        w_diff    = i_next_line - 10'(TEXT_Y);
        w_in_band = (i_next_line >= 10'(TEXT_Y)) && (w_diff < 10'(BAND_H));
`ifdef TITLE_DOUBLE_EN
        w_grow    = 6'(w_diff >> 1);
`else
        w_grow    = 6'(w_diff);
`endif
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // FSM next state: a line_start in any state restarts the sequence
    always_comb begin
        w_next_state = r_state;
        if (i_line_start) begin
            w_next_state = w_in_band ? S_FETCH : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next_state = S_IDLE;
                S_FETCH: if (r_k == LAST_K) w_next_state = S_LAST;
                S_LAST:  w_next_state = S_DONE;
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Address generation and row capture; rom_addr holds address k while
    // data for k-1 arrives, so capture trails the address by one cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_k         <= '0;
            r_grow      <= '0;
            r_line      <= '0;
            r_row_valid <= 1'b0;
            r_rom_addr  <= '0;
            r_buf       <= '0;
        end else if (i_line_start) begin
            r_line      <= i_next_line;
            r_row_valid <= 1'b0;
            if (w_in_band) begin
                r_grow     <= w_grow;
                r_k        <= '0;
                r_rom_addr <= f_addr('0, w_grow);
            end else begin
                r_buf      <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (r_k != '0) r_buf[r_k - K_W'(1)] <= i_rom_data;
                    if (r_k != LAST_K) begin
                        r_k        <= r_k + K_W'(1);
                        r_rom_addr <= f_addr(r_k + K_W'(1), r_grow);
                    end
                end
                S_LAST:  r_buf[LAST_K] <= i_rom_data;
                S_DONE:  r_row_valid   <= 1'b1;
                default: ;
            endcase
        end
    end

    assign o_rom_addr  = r_rom_addr;
    assign o_row       = r_buf;
    assign o_row_valid = r_row_valid && (i_draw_y == r_line);
    assign o_state     = r_state;

endmodule

// File: rtl/title_text_renderer.sv
// PACMAN title banner renderer: fetches glyph rows during hblank via
// title_row_fetch and shifts them out as a registered 1-bit text_on mask.
// Macro TITLE_DOUBLE_EN enables vertical 2x scaling (see title_row_fetch).
module title_text_renderer
    import title_pkg::*;
#(
    parameter int TEXT_X       = 240,
    parameter int TEXT_Y       = 100,
    parameter int NUM_CHARS    = 6,
    parameter int GLYPH_W      = 24,
    parameter int GLYPH_H      = 36,
    parameter int GLYPH_STRIDE = 64
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               line_start,
    input  logic [9:0]         next_line,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic [8:0]         rom_addr,
    input  logic [GLYPH_W-1:0] rom_data,
    output logic               text_on,
    output logic               busy
);

    localparam int C_W   = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int COL_W = $clog2(GLYPH_W);

    logic [NUM_CHARS-1:0][GLYPH_W-1:0] w_row;
    logic                              w_row_valid;
    fetch_state_e                      w_state;
    logic [C_W-1:0]                    r_char, w_cur_char, w_nxt_char;
    logic [COL_W-1:0]                  r_col, w_cur_col, w_nxt_col;
    logic                              r_in_span, w_cur_span, w_nxt_span;
    logic                              w_pix;
    logic                              r_text_on;

    title_row_fetch #(
        .TEXT_Y       (TEXT_Y),
        .NUM_CHARS    (NUM_CHARS),
        .GLYPH_W      (GLYPH_W),
        .GLYPH_H      (GLYPH_H),
        .GLYPH_STRIDE (GLYPH_STRIDE)
    ) u_fetch (
        .i_clk        (Clk),
        .i_rst_n      (Reset_n),
        .i_line_start (line_start),
        .i_next_line  (next_line),
        .i_draw_y     (DrawY),
        .i_rom_data   (rom_data),
        .o_rom_addr   (rom_addr),
        .o_row        (w_row),
        .o_row_valid  (w_row_valid),
        .o_state      (w_state)
    );

    // Position of the current DrawX inside the banner; TEXT_X forces the
    // start so the first pixel is registered on the same edge
    always_comb begin
        w_cur_char = r_char;
        w_cur_col  = r_col;
        w_cur_span = r_in_span;
        if (DrawX == 10'(TEXT_X)) begin
            w_cur_char = '0;
            w_cur_col  = '0;
            w_cur_span = 1'b1;
        end
        w_nxt_char = w_cur_char;
        w_nxt_col  = w_cur_col;
        w_nxt_span = w_cur_span;
        if (w_cur_span) begin
            if (w_cur_col == COL_W'(GLYPH_W - 1)) begin
                w_nxt_col = '0;
                if (w_cur_char == C_W'(NUM_CHARS - 1)) w_nxt_span = 1'b0;
                else                                   w_nxt_char = w_cur_char + C_W'(1);
            end else begin
                w_nxt_col = w_cur_col + COL_W'(1);
            end
        end
        // Bit GLYPH_W-1 is the leftmost pixel of a glyph row
        w_pix = w_cur_span & w_row[w_cur_char][COL_W'(GLYPH_W - 1) - w_cur_col];
    end

    // Display counters and the one-cycle-lagged pixel register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_char    <= '0;
            r_col     <= '0;
            r_in_span <= 1'b0;
            r_text_on <= 1'b0;
        end else begin
            r_char    <= w_nxt_char;
            r_col     <= w_nxt_col;
            r_in_span <= w_nxt_span;
            r_text_on <= w_row_valid & w_pix;
        end
    end

    assign text_on = r_text_on;
    assign busy    = (w_state == S_FETCH) || (w_state == S_LAST);

endmodule
